// File: rtl/argon_pkg.sv
// argon_pkg: encodings shared by the Argon core and its memory responder.
// Holds the read/write request masks, the MMIO register offsets, the
// access-size enum and small helpers for fault detection and read extension.
package argon_pkg;

    // Read request encodings (i_mem_rd_mask). Codes 6 and 7 mean no read.
    localparam logic [2:0] RDMASK_NONE = 3'd0;
    localparam logic [2:0] RDMASK_BS   = 3'd1;
    localparam logic [2:0] RDMASK_BU   = 3'd2;
    localparam logic [2:0] RDMASK_HS   = 3'd3;
    localparam logic [2:0] RDMASK_HU   = 3'd4;
    localparam logic [2:0] RDMASK_W    = 3'd5;

    // Write request encodings (i_mem_wr_mask).
    localparam logic [1:0] WRMASK_NONE = 2'd0;
    localparam logic [1:0] WRMASK_B    = 2'd1;
    localparam logic [1:0] WRMASK_H    = 2'd2;
    localparam logic [1:0] WRMASK_W    = 2'd3;

    // Byte offsets of the registers inside the 16-byte MMIO window.
    localparam logic [3:0] CON_TX     = 4'h0;
    localparam logic [3:0] CON_STATUS = 4'h4;
    localparam logic [3:0] CYCLE      = 4'h8;

    typedef enum logic [1:0] {
        SIZE_NONE,
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_e;

    function automatic access_size_e rd_size(input logic [2:0] mask);
        access_size_e s;
        case (mask)
            RDMASK_BS, RDMASK_BU: s = SIZE_BYTE;
            RDMASK_HS, RDMASK_HU: s = SIZE_HALF;
            RDMASK_W:             s = SIZE_WORD;
            default:              s = SIZE_NONE;
        endcase
        return s;
    endfunction

    function automatic access_size_e wr_size(input logic [1:0] mask);
        access_size_e s;
        case (mask)
            WRMASK_B: s = SIZE_BYTE;
            WRMASK_H: s = SIZE_HALF;
            WRMASK_W: s = SIZE_WORD;
            default:  s = SIZE_NONE;
        endcase
        return s;
    endfunction

    // True when an access of the given size is illegal at this address.
    // lo4 is addr[3:0]: alignment comes from its low bits, MMIO offset from all four.
    function automatic logic access_fault(input access_size_e size,
                                          input logic [3:0]   lo4,
                                          input logic         ram_hit,
                                          input logic         mmio_hit);
        logic f;
        f = 1'b0;
        if (!ram_hit && !mmio_hit)                   f = 1'b1;
        if (size == SIZE_HALF && lo4[0])             f = 1'b1;
        if (size == SIZE_WORD && lo4[1:0] != 2'b00)  f = 1'b1;
        if (mmio_hit && size != SIZE_WORD)           f = 1'b1;
        if (mmio_hit && lo4 == 4'hC)                 f = 1'b1;
        return f;
    endfunction

    // Sign- or zero-extends a right-aligned read value according to the mask.
    function automatic logic [31:0] rd_extend(input logic [31:0] shifted,
                                              input logic [2:0]  mask);
        logic [31:0] r;
        case (mask)
            RDMASK_BS: r = {{24{shifted[7]}}, shifted[7:0]};
            RDMASK_BU: r = {24'h0, shifted[7:0]};
            RDMASK_HS: r = {{16{shifted[15]}}, shifted[15:0]};
            RDMASK_HU: r = {16'h0, shifted[15:0]};
            default:   r = shifted;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/argon_mem_responder_if.sv
// argon_mem_responder_if: the Argon core memory port.
//   addr     byte address
//   wr_data  right-aligned write data
//   rd_mask  read request (argon_pkg RDMASK_*)
//   wr_mask  write request (argon_pkg WRMASK_*)
//   rd_data  registered, extended read result
// master = core side, slave = responder side.
interface argon_mem_responder_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_mask;
    logic [1:0]  wr_mask;
    logic [31:0] rd_data;

    modport master (output addr, wr_data, rd_mask, wr_mask, input rd_data);
    modport slave  (input addr, wr_data, rd_mask, wr_mask, output rd_data);
endinterface

// File: rtl/argon_con_fifo.sv
// argon_con_fifo: 8-bit synchronous FIFO for the console transmit path.
//   sys_clk, i_reset  clock, async active-high reset (flushes the FIFO)
//   push, push_data   write request and byte
//   pop               read request; ignored while empty
//   clear_overflow    clears the sticky overflow flag
//   head_data         entry at the head, 0 while empty
//   full, empty       occupancy flags
//   overflow          sticky: a push was dropped because the FIFO was full
module argon_con_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       i_reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clear_overflow,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    always_comb begin
        full      = (count == CNT_FULL);
        empty     = (count == '0);
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        head_data = empty ? 8'h00 : store[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && !do_push)    overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    // Storage carries no reset; empty masks the head so stale data never shows.
    always_ff @(posedge sys_clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/argon_mem_responder.sv
// argon_mem_responder: memory-side responder for the Argon core.
// Serves the core memory port from a byte-addressable word RAM or a 16-byte
// MMIO window (console FIFO, status, cycle counter).
//   sys_clk, i_reset  clock, async active-high reset
//   mem               core memory port (slave side)
//   o_con_data        console byte at the FIFO head
//   o_con_valid       FIFO non-empty
//   i_con_ready       consumer accepts the head byte
//   o_fault           sticky access fault
//   o_fault_addr      address of the first fault
module argon_mem_responder
    import argon_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter              INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          CON_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        i_reset,
    argon_mem_responder_if.slave        mem,
    output logic [7:0]                  o_con_data,
    output logic                        o_con_valid,
    input  logic                        i_con_ready,
    output logic                        o_fault,
    output logic [31:0]                 o_fault_addr
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]  ram [MEM_WORDS];

    access_size_e rsize;
    access_size_e wsize;
    logic         is_read;
    logic         is_write;
    logic         ram_hit;
    logic         mmio_hit;
    logic         rd_fault;
    logic         wr_fault;
    logic [AW-1:0] word_idx;
    logic [3:0]   mmio_off;
    logic [3:0]   byte_en;
    logic         ram_we;
    logic [31:0]  wr_aligned;
    logic [31:0]  ram_rd_shifted;
    logic [31:0]  mmio_rd_val;
    logic [31:0]  rd_next;
    logic [31:0]  rd_data_q;
    logic [31:0]  cycle_cnt;
    logic         con_push;
    logic         con_pop;
    logic         con_clr_ovf;
    logic         con_full;
    logic         con_empty;
    logic         con_overflow;

    // Decode the request: region, size, alignment faults, lanes and the read
    // value. Read and write are checked independently so a bad write cannot
    // poison a legal read in the same cycle and vice versa.
    always_comb begin
        rsize          = rd_size(mem.rd_mask);
        wsize          = wr_size(mem.wr_mask);
        is_read        = (rsize != SIZE_NONE);
        is_write       = (wsize != SIZE_NONE);
        ram_hit        = (mem.addr[31:AW+2] == '0);
        mmio_hit       = (mem.addr[31:4] == MMIO_BASE[31:4]);
        mmio_off       = mem.addr[3:0];
        word_idx       = mem.addr[AW+1:2];
        rd_fault       = is_read  && access_fault(rsize, mem.addr[3:0], ram_hit, mmio_hit);
        wr_fault       = is_write && access_fault(wsize, mem.addr[3:0], ram_hit, mmio_hit);

        case (wsize)
            SIZE_BYTE: byte_en = 4'b0001 << mem.addr[1:0];
            SIZE_HALF: byte_en = 4'b0011 << {mem.addr[1], 1'b0};
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
        ram_we         = is_write && !wr_fault && ram_hit;
        wr_aligned     = mem.wr_data << {mem.addr[1:0], 3'b000};
        ram_rd_shifted = ram[word_idx] >> {mem.addr[1:0], 3'b000};

        case (mmio_off)
            CON_STATUS: mmio_rd_val = {29'b0, con_overflow, con_empty, con_full};
            CYCLE:      mmio_rd_val = cycle_cnt;
            default:    mmio_rd_val = 32'h0;
        endcase

        if (rd_fault)     rd_next = 32'h0;
        else if (ram_hit) rd_next = rd_extend(ram_rd_shifted, mem.rd_mask);
        else              rd_next = mmio_rd_val;

        con_push    = is_write && !wr_fault && mmio_hit && (mmio_off == CON_TX);
        con_clr_ovf = is_write && !wr_fault && mmio_hit && (mmio_off == CON_STATUS)
                      && mem.wr_data[2];
        con_pop     = !con_empty && i_con_ready;
    end

    // RAM write port. Non-blocking update gives read-before-write for a read
    // sampled on the same edge. Contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[word_idx][8*b +: 8] <= wr_aligned[8*b +: 8];
            end
        end
    end

    // Read result register: loads only on read cycles, otherwise holds.
    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset)      rd_data_q <= 32'h0;
        else if (is_read) rd_data_q <= rd_next;
    end

    // Sticky fault capture: only the first faulting request is recorded.
    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            o_fault      <= 1'b0;
            o_fault_addr <= 32'h0;
        end else if ((rd_fault || wr_fault) && !o_fault) begin
            o_fault      <= 1'b1;
            o_fault_addr <= mem.addr;
        end
    end

    // Free-running cycle counter, wraps at 2^32.
    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) cycle_cnt <= 32'h0;
        else         cycle_cnt <= cycle_cnt + 32'h1;
    end

    assign mem.rd_data = rd_data_q;
    assign o_con_valid = !con_empty;

    argon_con_fifo #(
        .DEPTH(CON_DEPTH)
    ) u_con_fifo (
        .sys_clk       (sys_clk),
        .i_reset       (i_reset),
        .push          (con_push),
        .push_data     (mem.wr_data[7:0]),
        .pop           (con_pop),
        .clear_overflow(con_clr_ovf),
        .head_data     (o_con_data),
        .full          (con_full),
        .empty         (con_empty),
        .overflow      (con_overflow)
    );

endmodule

// File: tb/tb_argon_mem_responder.sv
// tb_argon_mem_responder: self-checking bench for argon_mem_responder.
// Inputs change on the falling edge, the DUT samples on the rising edge and
// outputs are compared on the following falling edge against a byte-level
// memory model and a queue-based console model.
module tb_argon_mem_responder;
    import argon_pkg::*;

    localparam int          MEM_WORDS = 4096;
    localparam int          RAM_BYTES = 4 * MEM_WORDS;
    localparam logic [31:0] MMIO      = 32'hFFFF_0000;

    logic        sys_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_con_ready;
    logic [7:0]  o_con_data;
    logic        o_con_valid;
    logic        o_fault;
    logic [31:0] o_fault_addr;

    argon_mem_responder_if mem_bus ();

    argon_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .INIT_FILE(""),
        .MMIO_BASE(MMIO),
        .CON_DEPTH(4)
    ) dut (
        .sys_clk     (sys_clk),
        .i_reset     (i_reset),
        .mem         (mem_bus),
        .o_con_data  (o_con_data),
        .o_con_valid (o_con_valid),
        .i_con_ready (i_con_ready),
        .o_fault     (o_fault),
        .o_fault_addr(o_fault_addr)
    );

    always #5 sys_clk = ~sys_clk;

    int          checkCount = 0;
    int          failCount  = 0;

    // Reference model state
    logic [7:0]  modelRam [RAM_BYTES];
    logic [7:0]  conQueue [$];
    logic        modelOverflow;
    logic [31:0] modelCycle;
    logic        modelFault;
    logic [31:0] modelFaultAddr;
    logic [31:0] modelRdData;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int sizeOfRead(input logic [2:0] m);
        case (m)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic int sizeOfWrite(input logic [1:0] m);
        return (m == 2'd3) ? 4 : int'(m);
    endfunction

    function automatic bit isMmio(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == MMIO;
    endfunction

    function automatic bit isFault(input logic [31:0] a, input int size);
        bit inRam;
        inRam = (a < RAM_BYTES);
        if (!inRam && !isMmio(a))            return 1'b1;
        if ((int'(a[1:0]) % size) != 0)      return 1'b1;
        if (isMmio(a) && size != 4)          return 1'b1;
        if (isMmio(a) && a[3:0] == 4'hC)     return 1'b1;
        return 1'b0;
    endfunction

    // One request cycle: drive, predict, clock, compare.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] rmask, input logic [1:0] wmask,
                                 input logic ready);
        int          rsz;
        int          wsz;
        bit          rdFault;
        bit          wrFault;
        logic [31:0] value;
        mem_bus.addr    = addr;
        mem_bus.wr_data = wdata;
        mem_bus.rd_mask = rmask;
        mem_bus.wr_mask = wmask;
        i_con_ready     = ready;

        rsz     = sizeOfRead(rmask);
        wsz     = sizeOfWrite(wmask);
        rdFault = (rsz != 0) && isFault(addr, rsz);
        wrFault = (wsz != 0) && isFault(addr, wsz);

        if (rsz != 0) begin
            if (rdFault) begin
                modelRdData = 32'h0;
            end else if (addr < RAM_BYTES) begin
                value = 32'h0;
                for (int i = 0; i < rsz; i++)
                    value = value | (32'(modelRam[int'(addr) + i]) << (8 * i));
                if (rmask == 3'd1 && value[7])  value = value | 32'hFFFF_FF00;
                if (rmask == 3'd3 && value[15]) value = value | 32'hFFFF_0000;
                modelRdData = value;
            end else begin
                case (addr[3:0])
                    4'h4:    modelRdData = {29'b0, modelOverflow, conQueue.size() == 0,
                                            conQueue.size() == 4};
                    4'h8:    modelRdData = modelCycle;
                    default: modelRdData = 32'h0;
                endcase
            end
        end

        if (conQueue.size() > 0 && ready) void'(conQueue.pop_front());
        if (wsz != 0 && !wrFault) begin
            if (addr < RAM_BYTES) begin
                for (int i = 0; i < wsz; i++) modelRam[int'(addr) + i] = wdata[8*i +: 8];
            end else if (addr[3:0] == 4'h0) begin
                if (conQueue.size() < 4) conQueue.push_back(wdata[7:0]);
                else                     modelOverflow = 1'b1;
            end else if (addr[3:0] == 4'h4 && wdata[2]) begin
                modelOverflow = 1'b0;
            end
        end
        if ((rdFault || wrFault) && !modelFault) begin
            modelFault     = 1'b1;
            modelFaultAddr = addr;
        end
        modelCycle = modelCycle + 32'h1;

        @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("rd_data", mem_bus.rd_data, modelRdData);
        checkOutput("con_valid", 32'(o_con_valid), 32'(conQueue.size() > 0));
        if (conQueue.size() > 0) checkOutput("con_data", 32'(o_con_data), 32'(conQueue[0]));
        checkOutput("fault", 32'(o_fault), 32'(modelFault));
        checkOutput("fault_addr", o_fault_addr, modelFaultAddr);
    endtask

    task automatic idle(input logic ready);
        applyStimulus(32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE, ready);
    endtask

    // Asserts reset asynchronously, checks the cleared outputs, releases it.
    task automatic resetDut();
        i_reset = 1'b1;
        #1;
        checkOutput("rst_rd_data", mem_bus.rd_data, 32'h0);
        checkOutput("rst_con_valid", 32'(o_con_valid), 32'h0);
        checkOutput("rst_con_data", 32'(o_con_data), 32'h0);
        checkOutput("rst_fault", 32'(o_fault), 32'h0);
        checkOutput("rst_fault_addr", o_fault_addr, 32'h0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        i_reset = 1'b0;
        conQueue.delete();
        modelOverflow  = 1'b0;
        modelCycle     = 32'h0;
        modelFault     = 1'b0;
        modelFaultAddr = 32'h0;
        modelRdData    = 32'h0;
    endtask

    initial begin
        logic [7:0]  lastByte;
        logic [31:0] ra;
        logic [2:0]  rm;
        logic [1:0]  wm;
        int          kind;

        mem_bus.addr    = 32'h0;
        mem_bus.wr_data = 32'h0;
        mem_bus.rd_mask = RDMASK_NONE;
        mem_bus.wr_mask = WRMASK_NONE;
        i_con_ready     = 1'b0;
        #1;
        resetDut();

        // Give the low RAM region and the top word known contents.
        for (int w = 0; w < 64; w++)
            applyStimulus(32'(4 * w), $urandom, RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(32'h3FFC, 32'hCAFE_BABE, RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(32'h3FFC, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("top_word", mem_bus.rd_data, 32'hCAFE_BABE);

        $display("[TB] mask coverage");
        applyStimulus(32'h10, 32'h8081_F2F3, RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(32'h10, 32'h0, RDMASK_BS, WRMASK_NONE, 1'b0);
        checkOutput("mask_bs", mem_bus.rd_data, 32'hFFFF_FFF3);
        applyStimulus(32'h13, 32'h0, RDMASK_BU, WRMASK_NONE, 1'b0);
        checkOutput("mask_bu", mem_bus.rd_data, 32'h0000_0080);
        applyStimulus(32'h12, 32'h0, RDMASK_HS, WRMASK_NONE, 1'b0);
        checkOutput("mask_hs", mem_bus.rd_data, 32'hFFFF_8081);
        applyStimulus(32'h12, 32'h0, RDMASK_HU, WRMASK_NONE, 1'b0);
        checkOutput("mask_hu", mem_bus.rd_data, 32'h0000_8081);
        applyStimulus(32'h10, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("mask_w", mem_bus.rd_data, 32'h8081_F2F3);

        $display("[TB] partial writes");
        applyStimulus(32'h20, 32'h0, RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(32'h21, 32'hAA, RDMASK_NONE, WRMASK_B, 1'b0);
        applyStimulus(32'h22, 32'hBEEF, RDMASK_NONE, WRMASK_H, 1'b0);
        applyStimulus(32'h20, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("partial", mem_bus.rd_data, 32'hBEEF_AA00);
        applyStimulus(32'h20, 32'h1122_3344, RDMASK_W, WRMASK_W, 1'b0);
        checkOutput("rd_before_wr", mem_bus.rd_data, 32'hBEEF_AA00);
        applyStimulus(32'h20, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("wr_visible", mem_bus.rd_data, 32'h1122_3344);

        $display("[TB] faults");
        applyStimulus(32'h31, 32'h0, RDMASK_HS, WRMASK_NONE, 1'b0);
        checkOutput("fault_rd", mem_bus.rd_data, 32'h0);
        checkOutput("fault_first", o_fault_addr, 32'h31);
        applyStimulus(32'h0010_0000, 32'h5, RDMASK_NONE, WRMASK_W, 1'b0);
        checkOutput("fault_sticky", o_fault_addr, 32'h31);
        applyStimulus(32'h0, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);

        $display("[TB] console overflow and drain");
        for (int i = 0; i < 5; i++)
            applyStimulus(MMIO, 32'(8'h41 + i), RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(MMIO + 4, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("status_ovf", mem_bus.rd_data, 32'h5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain", 32'(o_con_data), 32'(8'h41 + i));
            idle(1'b1);
        end
        applyStimulus(MMIO + 4, 32'h0, RDMASK_W, WRMASK_NONE, 1'b1);
        checkOutput("status_drained", mem_bus.rd_data, 32'h6);
        applyStimulus(MMIO + 4, 32'h4, RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(MMIO + 4, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("status_clr", mem_bus.rd_data, 32'h2);

        $display("[TB] full push with pop");
        for (int i = 0; i < 4; i++)
            applyStimulus(MMIO, 32'(8'h60 + i), RDMASK_NONE, WRMASK_W, 1'b0);
        applyStimulus(MMIO, 32'h50, RDMASK_NONE, WRMASK_W, 1'b1);
        applyStimulus(MMIO + 4, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("status_full", mem_bus.rd_data, 32'h1);
        lastByte = 8'h00;
        for (int i = 0; i < 4; i++) begin
            lastByte = o_con_data;
            idle(1'b1);
        end
        checkOutput("last_out", 32'(lastByte), 32'h50);

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 3; i++)
            applyStimulus(MMIO, 32'(8'h70 + i), RDMASK_NONE, WRMASK_W, 1'b0);
        idle(1'b1);
        resetDut();
        idle(1'b0);
        applyStimulus(MMIO + 8, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("cycle_restart", mem_bus.rd_data, 32'h1);
        applyStimulus(32'h20, 32'h0, RDMASK_W, WRMASK_NONE, 1'b0);
        checkOutput("ram_kept", mem_bus.rd_data, 32'h1122_3344);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 9);
            rm   = 3'($urandom_range(0, 7));
            wm   = 2'($urandom_range(0, 3));
            if (kind <= 5) begin
                ra = 32'($urandom_range(0, 255));
            end else if (kind <= 7) begin
                ra = MMIO + 32'($urandom_range(0, 3) * 4) + (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
                if ($urandom_range(0, 2) != 0) rm = RDMASK_W;
                if ($urandom_range(0, 2) != 0) wm = ($urandom_range(0, 1) != 0) ? WRMASK_W : WRMASK_NONE;
            end else if (kind == 8) begin
                case ($urandom_range(0, 3))
                    0:       ra = 32'h0000_4000;
                    1:       ra = 32'h0010_0000;
                    2:       ra = 32'hFFFF_0010;
                    default: ra = 32'hFFFE_FFFC;
                endcase
            end else begin
                ra = 32'h0;
                rm = RDMASK_NONE;
                wm = WRMASK_NONE;
            end
            applyStimulus(ra, $urandom, rm, wm, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
